// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw switch levels in, debounced level, edge pulses and sticky change flag out.
interface switch_debouncer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sw_in;
    logic             clr_change;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             change_flag;

    modport master (
        output sw_in,
        output clr_change,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  change_flag
    );

    modport slave (
        input  sw_in,
        input  clr_change,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output change_flag
    );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit 2-flop synchroniser plus stable-count debounce; emits clean levels,
// one-cycle rise/fall pulses and a sticky change flag for firmware.
module switch_debouncer #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_COUNTS = 500_000,
    parameter int unsigned      CNT_WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input logic               clk,
    input logic               rst,
    switch_debouncer_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNTS - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } bit_state_e;

    logic [WIDTH-1:0]     sync1_q;
    logic [WIDTH-1:0]     sync2_q;
    logic [WIDTH-1:0]     db_q;
    logic [WIDTH-1:0]     db_d;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     rise_d;
    logic [WIDTH-1:0]     fall_q;
    logic [WIDTH-1:0]     fall_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
    logic                 flag_q;
    logic                 flag_d;
    bit_state_e           state [WIDTH];

    // State registers; the synchroniser pair has nothing between its flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            db_q    <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            flag_q  <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.sw_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flag_q  <= flag_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-bit STABLE/PENDING decision; a bit is pending while sync2 disagrees with the accepted level.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        flag_d = flag_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            state[i] = STABLE;
            cnt_d[i] = '0;
        end

        for (int i = 0; i < int'(WIDTH); i++) begin
            state[i] = (sync2_q[i] != db_q[i]) ? PENDING : STABLE;
            case (state[i])
                STABLE: begin
                    cnt_d[i] = '0;
                end
                PENDING: begin
                    if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]   = sync2_q[i];
                        rise_d[i] = sync2_q[i];
                        fall_d[i] = ~sync2_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
        end

        // A fresh event outranks a simultaneous firmware clear.
        if (|(rise_d | fall_d)) begin
            flag_d = 1'b1;
        end else if (bus.clr_change) begin
            flag_d = 1'b0;
        end
    end

    assign bus.sw_db       = db_q;
    assign bus.sw_rise     = rise_q;
    assign bus.sw_fall     = fall_q;
    assign bus.change_flag = flag_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_COUNTS=4: vector table plus reset corner sequences.
module tb_switch_debouncer;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sw;
        logic             clr;
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             flag;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    switch_debouncer_if #(.WIDTH(WIDTH)) bus ();

    switch_debouncer #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_COUNTS(4),
        .CNT_WIDTH      (20),
        .RESET_VALUE    (8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [WIDTH-1:0] edb, input logic [WIDTH-1:0] erise,
                         input logic [WIDTH-1:0] efall, input logic eflag);
        n_checks++;
        if ({bus.sw_db, bus.sw_rise, bus.sw_fall, bus.change_flag} !== {edb, erise, efall, eflag}) begin
            n_fail++;
            $display("FAIL %s: got db=%h rise=%h fall=%h flag=%b, expected db=%h rise=%h fall=%h flag=%b",
                     nm, bus.sw_db, bus.sw_rise, bus.sw_fall, bus.change_flag, edb, erise, efall, eflag);
        end
    endtask

    function automatic void add(input logic [WIDTH-1:0] sw, input logic clr, input logic [WIDTH-1:0] db,
                                input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall, input logic flag);
        vec_t v;
        v.sw = sw; v.clr = clr; v.db = db; v.rise = rise; v.fall = fall; v.flag = flag;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [WIDTH-1:0] sw, input logic clr,
                                  input logic [WIDTH-1:0] db, input logic flag);
        for (int k = 0; k < n; k++) add(sw, clr, db, 8'h00, 8'h00, flag);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Row j: inputs driven before edge Ej, outputs checked just after Ej.
        // Clean 0->1 on bit0: accepted at E1+5.
        add_n(5, 8'h01, 1'b0, 8'h00, 1'b0);
        add(8'h01, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1);
        add_n(2, 8'h01, 1'b0, 8'h01, 1'b1);
        // Bit3 glitch of 3 cycles: rejected.
        add_n(3, 8'h09, 1'b0, 8'h01, 1'b1);
        add_n(4, 8'h01, 1'b0, 8'h01, 1'b1);
        // Bit3 pulse of 4 cycles: accepted, then its return to 0 is accepted too.
        add_n(4, 8'h09, 1'b0, 8'h01, 1'b1);
        add_n(1, 8'h01, 1'b0, 8'h01, 1'b1);
        add(8'h01, 1'b0, 8'h09, 8'h08, 8'h00, 1'b1);
        add_n(3, 8'h01, 1'b0, 8'h09, 1'b1);
        add(8'h01, 1'b0, 8'h01, 8'h00, 8'h08, 1'b1);
        add_n(1, 8'h01, 1'b0, 8'h01, 1'b1);
        // Back to 0x00, then a multi-bit step to 0xA5 on one edge.
        add_n(5, 8'h00, 1'b0, 8'h01, 1'b1);
        add(8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
        add_n(1, 8'h00, 1'b0, 8'h00, 1'b1);
        add_n(5, 8'hA5, 1'b0, 8'h00, 1'b1);
        add(8'hA5, 1'b0, 8'hA5, 8'hA5, 8'h00, 1'b1);
        add_n(1, 8'hA5, 1'b0, 8'hA5, 1'b1);
        // Clear coinciding with a fall: set wins; clear alone then drops the flag.
        add_n(5, 8'h00, 1'b0, 8'hA5, 1'b1);
        add(8'h00, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b1);
        add(8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        // Re-arm with 0xA5 so the async reset has something to clear.
        add_n(5, 8'hA5, 1'b0, 8'h00, 1'b0);
        add(8'hA5, 1'b0, 8'hA5, 8'hA5, 8'h00, 1'b1);
        add_n(1, 8'hA5, 1'b0, 8'hA5, 1'b1);

        bus.sw_in      = 8'h00;
        bus.clr_change = 1'b0;
        rst            = 1'b0;
        #2;
        check("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("idle%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            bus.sw_in      = vecs[i].sw;
            bus.clr_change = vecs[i].clr;
            step();
            check($sformatf("vec%0d", i), vecs[i].db, vecs[i].rise, vecs[i].fall, vecs[i].flag);
        end
        bus.clr_change = 1'b0;

        // Asynchronous reset asserted mid-cycle clears outputs before the next edge.
        #3;
        bus.sw_in = 8'h00;
        rst       = 1'b0;
        #1;
        check("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        check("async_reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);

        // 0xFF held; reset pulsed after two counting cycles, then full latency after release.
        rst       = 1'b1;
        bus.sw_in = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ff_count%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        rst = 1'b0;
        #1;
        check("midcount_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        check("midcount_reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("ff_release%0d", k),
                  (k >= 6) ? 8'hFF : 8'h00,
                  (k == 6) ? 8'hFF : 8'h00,
                  8'h00,
                  (k >= 6) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
